syrk_seq_ctrl: RTL and testbench
================================

Name: syrk_seq_ctrl

Overview:
Loop sequencer for the SYRK datapath that computes C = alpha*A*A^T + beta*C.
- Walks the i/j/k index space and issues the paired A-row read addresses to the dual-port A buffer.
- Issues a C read per output element for the beta*C term.
- Delay-matches first/last/write-back tags through the multiply-accumulate pipeline, so the top level contains no hand-counted magic cycles.
- Runs under a start/busy/done handshake with a global hold.

Parameters:
- N, 100, matrix dimension, with N >= 1.
- AW, 14, address width, with N*N <= 2**AW.
- PIPE_LAT, 6, cycles from A address issue to the product being valid at the accumulator input; PIPE_LAT >= 1.
- TRI, 0, selects the output range: 0 = full N×N output; 1 = lower triangle only (j <= i).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begins a run when sampled high in IDLE.
- hold, input, 1, freezes the whole controller (issue and tag pipeline) while high.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle pulse at end of run.
- a_rd_en, output, 1, A read strobe on both ports.
- a_addr_i, output, AW, i*N+k (row i of A).
- a_addr_j, output, AW, j*N+k (row j of A).
- c_rd_en, output, 1, C read strobe (beta*C operand).
- c_rd_addr, output, AW, i*N+j.
- mac_valid, output, 1, product at accumulator input is valid.
- mac_first, output, 1, accumulator loads instead of adding (k==0 term).
- mac_last, output, 1, final term of a dot product (k==N-1).
- c_wr_en, output, 1, write-back strobe for the finished C element.
- c_wr_addr, output, AW, i*N+j of the finished element.

Behaviour:
- Reset: state=IDLE; every output 0; i, j, k and all tag stages cleared.
- Reset mid-run aborts with no further c_wr_en or done.
- States:
  - IDLE: start=1 → ISSUE. busy rises the next cycle. start is ignored when not in IDLE.
  - ISSUE: one (i,j,k) per non-hold cycle, with a_rd_en=1.
    - k increments 0..N-1.
    - On wrap, j increments. Upper bound for j: N-1 when TRI=0, i when TRI=1.
    - On j wrap, i increments.
    - After issuing the final tuple (i=N-1, j=last, k=N-1) → DRAIN.
  - DRAIN: no issue. Waits until the tag pipeline is empty → DONE.
  - DONE: done=1 and busy=0 for one cycle → IDLE.
- Address generation:
  - Row bases are incremental registers (i*N and j*N maintained by adding N). No multipliers.
  - Addresses are registered and valid in the same cycle as a_rd_en.
- C read: c_rd_en=1 with c_rd_addr=i*N+j in the cycle the k==0 tuple of (i,j) is issued.
- Tag pipeline:
  - PIPE_LAT-deep shift register carrying {valid, first, last, i*N+j}.
  - mac_valid, mac_first and mac_last appear exactly PIPE_LAT non-hold cycles after the matching issue.
  - c_wr_en and c_wr_addr appear in the same cycle as mac_last.
- Hold:
  - While hold=1, issue counters, tag stages and all strobes freeze. a_rd_en, c_rd_en, mac_valid and c_wr_en are forced to 0.
  - The address and tag values themselves are retained.
  - hold in IDLE or DONE has no effect on start acceptance, and done is never suppressed.
- Latency:
  - Issue cycles: N*N*N for TRI=0; N*N*(N+1)/2 for TRI=1.
  - With start accepted at cycle 0 and no hold, the first issue is at cycle 1.
  - The last c_wr_en occurs at cycle (issue count + PIPE_LAT).
  - done pulses in the next cycle.
- Boundaries:
  - N=1: single tuple with mac_first=mac_last=1.
  - start and rst high together: rst wins.
  - start high in the cycle DONE pulses is ignored.
  - start held high continuously restarts at the first IDLE cycle.

Test Plan:
- N=3, PIPE_LAT=2, TRI=0, start at cycle 0.
  - Expected addresses: a_addr_i/a_addr_j issue 0/0, 1/1, 2/2, then 0/3, 1/4, 2/5, and so on.
  - Exactly 27 a_rd_en cycles, occurring at cycles 1–27.
  - c_wr_addr takes 0..8 in order.
  - Last c_wr_en at cycle 29, done at cycle 30.
- N=3, PIPE_LAT=2, TRI=1.
  - 18 issue cycles.
  - c_rd_addr and c_wr_addr take 0, 3, 4, 6, 7, 8.
  - done at cycle 21.
- Same as the first scenario, with hold high for 3 cycles at cycle 10.
  - Identical address and tag sequences.
  - No strobes during hold.
  - done at cycle 33.
- N=1, PIPE_LAT=6.
  - One issue at cycle 1 with addresses 0/0.
  - mac_first=mac_last=c_wr_en=1 at cycle 7.
  - done at cycle 8.
- Reset and restart.
  - rst at cycle 12 of the first scenario: the next cycle all outputs are 0 and the state is IDLE, with no c_wr_en afterwards.
  - A new start gives the full sequence again from address 0.
- start pulsed while busy at cycle 5 → no effect: the first scenario's sequence and done timing are unchanged.

Source files
------------

// File: rtl/syrk_seq_ctrl.sv
// rtl/syrk_seq_ctrl.sv - SYRK loop sequencer: i/j/k issue, C read, delay-matched MAC/write-back tags
module syrk_seq_ctrl #(
    parameter int N        = 100,
    parameter int AW       = 14,
    parameter int PIPE_LAT = 6,
    parameter int TRI      = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          a_rd_en,
    output logic [AW-1:0] a_addr_i,
    output logic [AW-1:0] a_addr_j,
    output logic          c_rd_en,
    output logic [AW-1:0] c_rd_addr,
    output logic          mac_valid,
    output logic          mac_first,
    output logic          mac_last,
    output logic          c_wr_en,
    output logic [AW-1:0] c_wr_addr
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] N_A  = AW'(N);
    localparam logic [AW-1:0] N_M1 = AW'(N - 1);

    state_t        state;
    logic [AW-1:0] i, j, k;
    logic [AW-1:0] row_i, row_j;

    logic [PIPE_LAT-1:0] tag_v, tag_f, tag_l;
    logic [AW-1:0]       tag_a [PIPE_LAT];

    logic k_last, j_last, final_tuple, issue_now;

    always_comb begin
        k_last      = (k == N_M1);
        j_last      = (TRI != 0) ? (j == i) : (j == N_M1);
        final_tuple = k_last && j_last && (i == N_M1);
        // the accepting edge already issues tuple 0 so the first a_rd_en lands one cycle after start
        issue_now   = !hold && ((state == ISSUE) || ((state == IDLE) && start));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_rd_en   <= 1'b0;
            a_addr_i  <= '0;
            a_addr_j  <= '0;
            c_rd_en   <= 1'b0;
            c_rd_addr <= '0;
            mac_valid <= 1'b0;
            mac_first <= 1'b0;
            mac_last  <= 1'b0;
            c_wr_en   <= 1'b0;
            c_wr_addr <= '0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            row_i     <= '0;
            row_j     <= '0;
            tag_v     <= '0;
            tag_f     <= '0;
            tag_l     <= '0;
            for (int p = 0; p < PIPE_LAT; p++) begin
                tag_a[p] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= (issue_now && final_tuple) ? DRAIN : ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (issue_now && final_tuple) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!hold && (tag_v == '0)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    i     <= '0;
                    j     <= '0;
                    k     <= '0;
                    row_i <= '0;
                    row_j <= '0;
                end
                default: state <= IDLE;
            endcase

            // row bases advance by N on each wrap, so no multiplier sits in the address path
            if (issue_now) begin
                if (k_last) begin
                    k <= '0;
                    if (j_last) begin
                        j     <= '0;
                        row_j <= '0;
                        i     <= i + 1'b1;
                        row_i <= row_i + N_A;
                    end else begin
                        j     <= j + 1'b1;
                        row_j <= row_j + N_A;
                    end
                end else begin
                    k <= k + 1'b1;
                end
            end

            if (hold) begin
                a_rd_en   <= 1'b0;
                c_rd_en   <= 1'b0;
                mac_valid <= 1'b0;
                c_wr_en   <= 1'b0;
            end else begin
                a_rd_en <= issue_now;
                c_rd_en <= issue_now && (k == '0);
                if (issue_now) begin
                    a_addr_i <= row_i + k;
                    a_addr_j <= row_j + k;
                    if (k == '0) begin
                        c_rd_addr <= row_i + j;
                    end
                end

                for (int p = PIPE_LAT - 1; p > 0; p--) begin
                    tag_v[p] <= tag_v[p-1];
                    tag_f[p] <= tag_f[p-1];
                    tag_l[p] <= tag_l[p-1];
                    tag_a[p] <= tag_a[p-1];
                end
                tag_v[0] <= issue_now;
                tag_f[0] <= issue_now && (k == '0);
                tag_l[0] <= issue_now && k_last;
                tag_a[0] <= row_i + j;

                mac_valid <= tag_v[PIPE_LAT-1];
                mac_first <= tag_v[PIPE_LAT-1] && tag_f[PIPE_LAT-1];
                mac_last  <= tag_v[PIPE_LAT-1] && tag_l[PIPE_LAT-1];
                c_wr_en   <= tag_v[PIPE_LAT-1] && tag_l[PIPE_LAT-1];
                if (tag_v[PIPE_LAT-1] && tag_l[PIPE_LAT-1]) begin
                    c_wr_addr <= tag_a[PIPE_LAT-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_syrk_seq_ctrl.sv
// tb/tb_syrk_seq_ctrl.sv - bench for syrk_seq_ctrl: directed scenario table plus randomized run against a tuple-list model
module tb_syrk_seq_ctrl;

    localparam int AW = 8;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_v [NI];
    logic start_v [NI];
    logic hold_v [NI];

    logic          busy_o [NI];
    logic          done_o [NI];
    logic          a_en_o [NI];
    logic [AW-1:0] ai_o [NI];
    logic [AW-1:0] aj_o [NI];
    logic          crd_en_o [NI];
    logic [AW-1:0] crd_o [NI];
    logic          mac_v_o [NI];
    logic          mac_f_o [NI];
    logic          mac_l_o [NI];
    logic          wr_en_o [NI];
    logic [AW-1:0] wr_o [NI];

    syrk_seq_ctrl #(.N(3), .AW(AW), .PIPE_LAT(2), .TRI(0)) u_full (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .hold(hold_v[0]),
        .busy(busy_o[0]), .done(done_o[0]), .a_rd_en(a_en_o[0]),
        .a_addr_i(ai_o[0]), .a_addr_j(aj_o[0]), .c_rd_en(crd_en_o[0]), .c_rd_addr(crd_o[0]),
        .mac_valid(mac_v_o[0]), .mac_first(mac_f_o[0]), .mac_last(mac_l_o[0]),
        .c_wr_en(wr_en_o[0]), .c_wr_addr(wr_o[0])
    );

    syrk_seq_ctrl #(.N(3), .AW(AW), .PIPE_LAT(2), .TRI(1)) u_tri (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .hold(hold_v[1]),
        .busy(busy_o[1]), .done(done_o[1]), .a_rd_en(a_en_o[1]),
        .a_addr_i(ai_o[1]), .a_addr_j(aj_o[1]), .c_rd_en(crd_en_o[1]), .c_rd_addr(crd_o[1]),
        .mac_valid(mac_v_o[1]), .mac_first(mac_f_o[1]), .mac_last(mac_l_o[1]),
        .c_wr_en(wr_en_o[1]), .c_wr_addr(wr_o[1])
    );

    syrk_seq_ctrl #(.N(1), .AW(AW), .PIPE_LAT(6), .TRI(0)) u_one (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .hold(hold_v[2]),
        .busy(busy_o[2]), .done(done_o[2]), .a_rd_en(a_en_o[2]),
        .a_addr_i(ai_o[2]), .a_addr_j(aj_o[2]), .c_rd_en(crd_en_o[2]), .c_rd_addr(crd_o[2]),
        .mac_valid(mac_v_o[2]), .mac_first(mac_f_o[2]), .mac_last(mac_l_o[2]),
        .c_wr_en(wr_en_o[2]), .c_wr_addr(wr_o[2])
    );

    typedef struct {
        int ai;
        int aj;
        int ca;
        bit f;
        bit l;
    } tup_t;

    typedef struct {
        int inst;
        int hold_at;
        int hold_len;
        int pulse_at;
        int rst_at;
        int start_until;
        int e_first_done;
        int e_dones;
        int e_issues;
        int e_wrs;
        int e_last_wr;
    } scn_t;

    int pn [NI];
    int pl [NI];
    int ptri [NI];
    int base [NI];
    int cnt [NI];
    int ph [NI];
    int ecnt [NI];
    tup_t tl [64];
    scn_t scn [8];

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input int g, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", nm, g, $time, act, exp);
        end
    endtask

    // Reference: run = ordered tuple list; the m-th non-hold edge issues tuple m,
    // retires tuple m-PIPE_LAT, and edge count+PIPE_LAT raises done.
    task automatic step(input int g);
        bit   ea, em, ed, eb;
        tup_t ta, tm;
        int   m;
        ea = 0; em = 0; ed = 0; eb = 0;
        ta = '{0, 0, 0, 1'b0, 1'b0};
        tm = ta;
        if (rst_v[g]) begin
            ph[g] = 0;
            chk("rst_a_addr_i", g, int'(ai_o[g]), 0);
            chk("rst_a_addr_j", g, int'(aj_o[g]), 0);
            chk("rst_c_rd_addr", g, int'(crd_o[g]), 0);
            chk("rst_c_wr_addr", g, int'(wr_o[g]), 0);
            chk("rst_mac_first", g, int'(mac_f_o[g]), 0);
            chk("rst_mac_last", g, int'(mac_l_o[g]), 0);
        end else if (ph[g] == 2) begin
            ph[g] = 0;
        end else begin
            if (ph[g] == 0 && start_v[g]) begin
                ph[g] = 1;
                ecnt[g] = 0;
            end
            if (ph[g] == 1) begin
                eb = 1;
                if (!hold_v[g]) begin
                    m = ecnt[g];
                    ecnt[g]++;
                    if (m < cnt[g]) begin
                        ea = 1;
                        ta = tl[base[g] + m];
                    end
                    if (m >= pl[g] && m - pl[g] < cnt[g]) begin
                        em = 1;
                        tm = tl[base[g] + m - pl[g]];
                    end
                    if (m == cnt[g] + pl[g]) begin
                        ed = 1;
                        eb = 0;
                        ph[g] = 2;
                    end
                end
            end
        end
        chk("busy", g, int'(busy_o[g]), int'(eb));
        chk("done", g, int'(done_o[g]), int'(ed));
        chk("a_rd_en", g, int'(a_en_o[g]), int'(ea));
        chk("c_rd_en", g, int'(crd_en_o[g]), int'(ea && ta.f));
        chk("mac_valid", g, int'(mac_v_o[g]), int'(em));
        chk("c_wr_en", g, int'(wr_en_o[g]), int'(em && tm.l));
        if (ea) begin
            chk("a_addr_i", g, int'(ai_o[g]), ta.ai);
            chk("a_addr_j", g, int'(aj_o[g]), ta.aj);
        end
        if (ea && ta.f) chk("c_rd_addr", g, int'(crd_o[g]), ta.ca);
        if (em) begin
            chk("mac_first", g, int'(mac_f_o[g]), int'(tm.f));
            chk("mac_last", g, int'(mac_l_o[g]), int'(tm.l));
        end
        if (em && tm.l) chk("c_wr_addr", g, int'(wr_o[g]), tm.ca);
    endtask

    task automatic cycle_and_check();
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) step(g);
    endtask

    task automatic set_in(input scn_t s, input int cyc);
        for (int g = 0; g < NI; g++) begin
            rst_v[g] = 1'b0;
            start_v[g] = 1'b0;
            hold_v[g] = 1'b0;
        end
        rst_v[s.inst]   = (cyc == s.rst_at);
        start_v[s.inst] = (cyc < s.start_until) || (cyc == s.pulse_at);
        hold_v[s.inst]  = (s.hold_at >= 0) && (cyc >= s.hold_at) && (cyc < s.hold_at + s.hold_len);
    endtask

    task automatic run_scn(input int idx, input scn_t s);
        int issues = 0;
        int wrs = 0;
        int dones = 0;
        int first_done = 0;
        int last_wr = 0;
        set_in(s, 0);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            cycle_and_check();
            if (a_en_o[s.inst]) issues++;
            if (wr_en_o[s.inst]) begin
                wrs++;
                last_wr = cyc;
            end
            if (done_o[s.inst]) begin
                dones++;
                if (first_done == 0) first_done = cyc;
            end
            set_in(s, cyc);
        end
        chk($sformatf("scn%0d_first_done_cycle", idx), s.inst, first_done, s.e_first_done);
        chk($sformatf("scn%0d_done_count", idx), s.inst, dones, s.e_dones);
        chk($sformatf("scn%0d_issue_count", idx), s.inst, issues, s.e_issues);
        chk($sformatf("scn%0d_wr_count", idx), s.inst, wrs, s.e_wrs);
        chk($sformatf("scn%0d_last_wr_cycle", idx), s.inst, last_wr, s.e_last_wr);
    endtask

    initial begin
        int idx;
        pn   = '{3, 3, 1};
        pl   = '{2, 2, 6};
        ptri = '{0, 1, 0};

        idx = 0;
        for (int g = 0; g < NI; g++) begin
            base[g] = idx;
            for (int i = 0; i < pn[g]; i++) begin
                for (int j = 0; j <= ((ptri[g] != 0) ? i : pn[g] - 1); j++) begin
                    for (int k = 0; k < pn[g]; k++) begin
                        tl[idx] = '{i * pn[g] + k, j * pn[g] + k, i * pn[g] + j, k == 0, k == pn[g] - 1};
                        idx++;
                    end
                end
            end
            cnt[g] = idx - base[g];
            ph[g] = 0;
            ecnt[g] = 0;
        end

        //           inst hold len pulse rst  st  1stdone dones issues wrs lastwr
        scn[0] = '{0, -1, 0, -1, -1,  1, 30, 1, 27, 9, 29};
        scn[1] = '{1, -1, 0, -1, -1,  1, 21, 1, 18, 6, 20};
        scn[2] = '{0, 10, 3, -1, -1,  1, 33, 1, 27, 9, 32};
        scn[3] = '{2, -1, 0, -1, -1,  1,  8, 1,  1, 1,  7};
        scn[4] = '{0, -1, 0, -1, 12,  1,  0, 0, 12, 3, 11};
        scn[5] = '{0, -1, 0, -1, -1,  1, 30, 1, 27, 9, 29};
        scn[6] = '{0, -1, 0,  5, -1,  1, 30, 1, 27, 9, 29};
        scn[7] = '{2, -1, 0, -1, -1, 40,  8, 5,  5, 5, 43};

        for (int g = 0; g < NI; g++) begin
            rst_v[g] = 1'b1;
            start_v[g] = (g == 1);
            hold_v[g] = 1'b0;
        end
        for (int c = 0; c < 3; c++) cycle_and_check();

        for (int s = 0; s < 8; s++) run_scn(s, scn[s]);

        for (int c = 0; c < 3000; c++) begin
            for (int g = 0; g < NI; g++) begin
                rst_v[g]   = ($urandom_range(0, 199) == 0);
                start_v[g] = ($urandom_range(0, 3) == 0);
                hold_v[g]  = ($urandom_range(0, 3) == 0);
            end
            cycle_and_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
